// File: rtl/otter_cu_fsm_mc.sv
// Multicycle control unit for the OTTER core: ready-handshaked memory ports,
// per-access timeout, synchronous traps and prioritised edge/level interrupts.
module otter_cu_fsm_mc #(
  parameter int               N_IRQ     = 4,
  parameter logic [N_IRQ-1:0] EDGE_MASK = {N_IRQ{1'b1}},
  parameter int               TIMEOUT   = 255,
  parameter int               CNT_W     = 8,
  localparam int              IRQ_W     = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instrn,
  input  logic             mem_misalign,
  input  logic             mem_rdy,
  input  logic [N_IRQ-1:0] irq,
  input  logic             irq_en,
  output logic             pc_w_en,
  output logic             rfile_w_en,
  output logic             mem_we2,
  output logic             mem_rden1,
  output logic             mem_rden2,
  output logic             cu_rst,
  output logic             csr_we,
  output logic             intrpt_taken,
  output logic [IRQ_W-1:0] irq_id,
  output logic             trap_taken,
  output logic [3:0]       trap_cause,
  output logic [N_IRQ-1:0] irq_pending
);

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_EXEC     = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_WR_BK    = 3'd4,
    ST_INTRPT   = 3'd5,
    ST_TRAP     = 3'd6
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  localparam logic [3:0] CAUSE_FETCH_TO  = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISAL  = 4'd4;
  localparam logic [3:0] CAUSE_LD_TO     = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISAL  = 4'd6;
  localparam logic [3:0] CAUSE_ST_TO     = 4'd7;

  localparam bit               TO_EN   = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_store, w_store_next;
  logic [N_IRQ-1:0]   r_pending, w_pending_next;
  logic [N_IRQ-1:0]   r_irq_prev;
  logic [IRQ_W-1:0]   r_irq_id, w_lowest;
  logic [3:0]         r_trap_cause, w_cause;
  logic               w_waiting, w_timeout, w_done, w_trap_go;
  logic [6:0]         w_opcode;
  logic               w_unused;

  assign w_opcode  = instrn[6:0];
  assign w_unused  = ^{instrn[31:15], instrn[11:7]};
  assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEM_WAIT);
  // The timeout only fires on a not-ready cycle; a ready in the same cycle wins.
  assign w_timeout = TO_EN && w_waiting && !mem_rdy && (r_cnt == TO_LAST);

  // NOTE: always_comb assigns every output a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next       = r_state;
    w_store_next = r_is_store;
    w_cause      = r_trap_cause;
    w_done       = 1'b0;
    w_trap_go    = 1'b0;
    pc_w_en      = 1'b1;
    rfile_w_en   = 1'b0;
    mem_we2      = 1'b0;
    mem_rden1    = 1'b0;
    mem_rden2    = 1'b0;
    cu_rst       = 1'b0;
    csr_we       = 1'b0;
    intrpt_taken = 1'b0;
    trap_taken   = 1'b0;

    case (r_state)
      ST_INIT: begin
        pc_w_en = 1'b0;
        cu_rst  = 1'b1;
        w_next  = ST_FETCH;
      end
      ST_FETCH: begin
        pc_w_en   = 1'b0;
        mem_rden1 = 1'b1;
        if (mem_rdy) begin
          w_next = ST_EXEC;
        end else if (w_timeout) begin
          w_trap_go = 1'b1;
          w_cause   = CAUSE_FETCH_TO;
        end
      end
      ST_EXEC: begin
        case (w_opcode)
          OP_REG, OP_IMM, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL: begin
            rfile_w_en = 1'b1;
            w_done     = 1'b1;
          end
          OP_SYS: begin
            csr_we     = instrn[12];
            rfile_w_en = instrn[12];
            w_done     = 1'b1;
          end
          OP_BRANCH: w_done = 1'b1;
          OP_LOAD: begin
            pc_w_en = 1'b0;
            if (mem_misalign) begin
              w_trap_go = 1'b1;
              w_cause   = CAUSE_LD_MISAL;
            end else begin
              mem_rden2    = 1'b1;
              w_store_next = 1'b0;
              w_next       = ST_MEM_WAIT;
            end
          end
          OP_STORE: begin
            if (mem_misalign) begin
              pc_w_en   = 1'b0;
              w_trap_go = 1'b1;
              w_cause   = CAUSE_ST_MISAL;
            end else begin
              mem_we2      = 1'b1;
              w_store_next = 1'b1;
              if (mem_rdy) begin
                w_done = 1'b1;
              end else begin
                pc_w_en = 1'b0;
                w_next  = ST_MEM_WAIT;
              end
            end
          end
          default: begin
            pc_w_en   = 1'b0;
            w_trap_go = 1'b1;
            w_cause   = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_MEM_WAIT: begin
        pc_w_en   = 1'b0;
        mem_we2   = r_is_store;
        mem_rden2 = !r_is_store;
        if (mem_rdy) begin
          if (r_is_store) begin
            pc_w_en = 1'b1;
            w_done  = 1'b1;
          end else begin
            w_next = ST_WR_BK;
          end
        end else if (w_timeout) begin
          w_trap_go = 1'b1;
          w_cause   = r_is_store ? CAUSE_ST_TO : CAUSE_LD_TO;
        end
      end
      ST_WR_BK: begin
        rfile_w_en = 1'b1;
        w_done     = 1'b1;
      end
      ST_INTRPT: begin
        intrpt_taken = 1'b1;
        w_next       = ST_FETCH;
      end
      ST_TRAP: begin
        trap_taken = 1'b1;
        w_next     = ST_FETCH;
      end
      default: begin
        pc_w_en = 1'b0;
        w_next  = ST_INIT;
      end
    endcase

    if (w_done) w_next = (irq_en && (|r_pending)) ? ST_INTRPT : ST_FETCH;
    if (w_trap_go) w_next = ST_TRAP;
  end

  // Pending vector update and lowest-index priority pick.
  always_comb begin
    w_pending_next = '0;
    w_lowest       = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (EDGE_MASK[i]) begin
        w_pending_next[i] = (irq[i] && !r_irq_prev[i]) ||
                            (r_pending[i] &&
                             !((r_state == ST_INTRPT) && (r_irq_id == IRQ_W'(i))));
      end else begin
        w_pending_next[i] = irq[i];
      end
    end
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (r_pending[i]) w_lowest = IRQ_W'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_INIT;
      r_cnt        <= '0;
      r_is_store   <= 1'b0;
      r_pending    <= '0;
      r_irq_prev   <= '0;
      r_irq_id     <= '0;
      r_trap_cause <= '0;
    end else begin
      r_state    <= w_next;
      r_is_store <= w_store_next;
      r_pending  <= w_pending_next;
      r_irq_prev <= irq;
      // Counter restarts whenever a wait state is left, so each entry starts at 0.
      if (TO_EN && w_waiting && !mem_rdy && !w_timeout) r_cnt <= r_cnt + 1'b1;
      else                                             r_cnt <= '0;
      if (w_next == ST_INTRPT) r_irq_id <= w_lowest;
      if (w_next == ST_TRAP)   r_trap_cause <= w_cause;
    end
  end

  assign irq_id      = r_irq_id;
  assign trap_cause  = r_trap_cause;
  assign irq_pending = r_pending;

endmodule

// File: tb/tb_otter_cu_fsm_mc.sv
// Directed-vector bench for otter_cu_fsm_mc: stimulus pushes the expected
// per-cycle outputs into a queue; a monitor pops and compares on each falling edge.
module tb_otter_cu_fsm_mc;

  localparam logic [31:0] I_ADDI  = 32'h00100093;
  localparam logic [31:0] I_ADD   = 32'h002081b3;
  localparam logic [31:0] I_LW    = 32'h0000a103;
  localparam logic [31:0] I_SW    = 32'h0020a023;
  localparam logic [31:0] I_ILL   = 32'h00000000;
  localparam logic [31:0] I_CSRRW = 32'h30529073;
  localparam logic [31:0] I_BEQ   = 32'h00208063;

  // Expected control vector bit order:
  // {pc_w_en, rfile_w_en, mem_we2, mem_rden1, mem_rden2, cu_rst, csr_we, intrpt_taken, trap_taken}
  localparam logic [8:0] Z = 9'b000000000;
  localparam logic [8:0] P = 9'b100000000;
  localparam logic [8:0] R = 9'b010000000;
  localparam logic [8:0] W = 9'b001000000;
  localparam logic [8:0] F = 9'b000100000;
  localparam logic [8:0] L = 9'b000010000;
  localparam logic [8:0] C = 9'b000001000;
  localparam logic [8:0] S = 9'b000000100;
  localparam logic [8:0] I = 9'b000000010;
  localparam logic [8:0] T = 9'b000000001;

  typedef struct {
    string      name;
    logic [8:0] ctrl;
    logic [1:0] id;
    logic [3:0] cause;
    logic [3:0] pend;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instrn = '0;
  logic        mem_misalign = 1'b0;
  logic        mem_rdy = 1'b0;
  logic [3:0]  irq = '0;
  logic        irq_en = 1'b0;
  logic        pc_w_en, rfile_w_en, mem_we2, mem_rden1, mem_rden2, cu_rst, csr_we;
  logic        intrpt_taken, trap_taken;
  logic [1:0]  irq_id;
  logic [3:0]  trap_cause;
  logic [3:0]  irq_pending;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   stim_done = 1'b0;

  always #5 clk = ~clk;

  otter_cu_fsm_mc #(
    .N_IRQ    (4),
    .EDGE_MASK(4'b0111),
    .TIMEOUT  (4),
    .CNT_W    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instrn      (instrn),
    .mem_misalign(mem_misalign),
    .mem_rdy     (mem_rdy),
    .irq         (irq),
    .irq_en      (irq_en),
    .pc_w_en     (pc_w_en),
    .rfile_w_en  (rfile_w_en),
    .mem_we2     (mem_we2),
    .mem_rden1   (mem_rden1),
    .mem_rden2   (mem_rden2),
    .cu_rst      (cu_rst),
    .csr_we      (csr_we),
    .intrpt_taken(intrpt_taken),
    .irq_id      (irq_id),
    .trap_taken  (trap_taken),
    .trap_cause  (trap_cause),
    .irq_pending (irq_pending)
  );

  // One cycle of stimulus: drive inputs just after the rising edge and queue the
  // outputs expected while the DUT sits in the current state.
  task automatic step(input string nm, input logic rst, input logic [31:0] ins,
                      input logic mis, input logic rdy, input logic [3:0] irqv,
                      input logic en, input logic [8:0] ctl, input logic [1:0] id,
                      input logic [3:0] cause, input logic [3:0] pend);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n        = rst;
    instrn       = ins;
    mem_misalign = mis;
    mem_rdy      = rdy;
    irq          = irqv;
    irq_en       = en;
    e.name  = nm;
    e.ctrl  = ctl;
    e.id    = id;
    e.cause = cause;
    e.pend  = pend;
    exp_q.push_back(e);
  endtask

  task automatic check(input exp_t e);
    logic [8:0] got;
    got = {pc_w_en, rfile_w_en, mem_we2, mem_rden1, mem_rden2, cu_rst, csr_we,
           intrpt_taken, trap_taken};
    n_tests++;
    if (got !== e.ctrl || irq_id !== e.id || trap_cause !== e.cause ||
        irq_pending !== e.pend) begin
      n_fail++;
      $display("FAIL %s: got ctrl=%b id=%0d cause=%0d pend=%b, expected ctrl=%b id=%0d cause=%0d pend=%b",
               e.name, got, irq_id, trap_cause, irq_pending, e.ctrl, e.id, e.cause, e.pend);
    end
  endtask

  // Monitor: owns the counters and the summary line.
  initial begin
    int idle;
    exp_t e;
    idle = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e);
        idle = 0;
      end else if (stim_done) begin
        break;
      end else if (++idle > 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got no stimulus for %0d cycles, expected steady stream", idle);
        break;
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no end of run, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    // Reset and ADDI with memory always ready.
    step("reset_hold",  0, I_ADDI, 0, 1, 4'b0000, 0, C,     0, 0, 4'b0000);
    step("init",        1, I_ADDI, 0, 1, 4'b0000, 0, C,     0, 0, 4'b0000);
    step("addi_fetch",  1, I_ADDI, 0, 1, 4'b0000, 0, F,     0, 0, 4'b0000);
    step("addi_exec",   1, I_ADDI, 0, 1, 4'b0000, 0, P|R,   0, 0, 4'b0000);
    step("add_fetch",   1, I_ADD,  0, 1, 4'b0000, 0, F,     0, 0, 4'b0000);
    step("add_exec",    1, I_ADD,  0, 1, 4'b0000, 0, P|R,   0, 0, 4'b0000);
    // LW with wait states.
    step("lw_fetch",    1, I_LW,   0, 1, 4'b0000, 0, F,     0, 0, 4'b0000);
    step("lw_exec",     1, I_LW,   0, 0, 4'b0000, 0, L,     0, 0, 4'b0000);
    step("lw_wait0",    1, I_LW,   0, 0, 4'b0000, 0, L,     0, 0, 4'b0000);
    step("lw_wait1",    1, I_LW,   0, 0, 4'b0000, 0, L,     0, 0, 4'b0000);
    step("lw_wait_rdy", 1, I_LW,   0, 1, 4'b0000, 0, L,     0, 0, 4'b0000);
    step("lw_wrbk",     1, I_LW,   0, 1, 4'b0000, 0, P|R,   0, 0, 4'b0000);
    // SW completing in EXEC.
    step("sw_fetch",    1, I_SW,   0, 1, 4'b0000, 0, F,     0, 0, 4'b0000);
    step("sw_exec_rdy", 1, I_SW,   0, 1, 4'b0000, 0, P|W,   0, 0, 4'b0000);
    // SW where ready arrives on the last tolerated cycle.
    step("sw2_fetch",   1, I_SW,   0, 1, 4'b0000, 0, F,     0, 0, 4'b0000);
    step("sw2_exec",    1, I_SW,   0, 0, 4'b0000, 0, W,     0, 0, 4'b0000);
    step("sw2_wait0",   1, I_SW,   0, 0, 4'b0000, 0, W,     0, 0, 4'b0000);
    step("sw2_wait1",   1, I_SW,   0, 0, 4'b0000, 0, W,     0, 0, 4'b0000);
    step("sw2_wait2",   1, I_SW,   0, 0, 4'b0000, 0, W,     0, 0, 4'b0000);
    step("sw2_rdy_win", 1, I_SW,   0, 1, 4'b0000, 0, P|W,   0, 0, 4'b0000);
    // SW timeout.
    step("sw3_fetch",   1, I_SW,   0, 1, 4'b0000, 0, F,     0, 0, 4'b0000);
    step("sw3_exec",    1, I_SW,   0, 0, 4'b0000, 0, W,     0, 0, 4'b0000);
    step("sw3_wait0",   1, I_SW,   0, 0, 4'b0000, 0, W,     0, 0, 4'b0000);
    step("sw3_wait1",   1, I_SW,   0, 0, 4'b0000, 0, W,     0, 0, 4'b0000);
    step("sw3_wait2",   1, I_SW,   0, 0, 4'b0000, 0, W,     0, 0, 4'b0000);
    step("sw3_wait3",   1, I_SW,   0, 0, 4'b0000, 0, W,     0, 0, 4'b0000);
    step("sw3_trap",    1, I_SW,   0, 1, 4'b0000, 0, P|T,   0, 7, 4'b0000);
    // Illegal opcode.
    step("ill_fetch",   1, I_ILL,  0, 1, 4'b0000, 0, F,     0, 7, 4'b0000);
    step("ill_exec",    1, I_ILL,  0, 1, 4'b0000, 0, Z,     0, 7, 4'b0000);
    step("ill_trap",    1, I_ILL,  0, 1, 4'b0000, 0, P|T,   0, 2, 4'b0000);
    // Misaligned LW.
    step("mis_fetch",   1, I_LW,   0, 1, 4'b0000, 0, F,     0, 2, 4'b0000);
    step("mis_exec",    1, I_LW,   1, 1, 4'b0000, 0, Z,     0, 2, 4'b0000);
    step("mis_trap",    1, I_LW,   0, 1, 4'b0000, 0, P|T,   0, 4, 4'b0000);
    // Fetch timeout.
    step("fto_wait0",   1, I_ADDI, 0, 0, 4'b0000, 0, F,     0, 4, 4'b0000);
    step("fto_wait1",   1, I_ADDI, 0, 0, 4'b0000, 0, F,     0, 4, 4'b0000);
    step("fto_wait2",   1, I_ADDI, 0, 0, 4'b0000, 0, F,     0, 4, 4'b0000);
    step("fto_wait3",   1, I_ADDI, 0, 0, 4'b0000, 0, F,     0, 4, 4'b0000);
    step("fto_trap",    1, I_ADDI, 0, 1, 4'b0000, 0, P|T,   0, 1, 4'b0000);
    // CSRRW and BEQ decode.
    step("csr_fetch",   1, I_CSRRW,0, 1, 4'b0000, 0, F,     0, 1, 4'b0000);
    step("csr_exec",    1, I_CSRRW,0, 1, 4'b0000, 0, P|R|S, 0, 1, 4'b0000);
    step("beq_fetch",   1, I_BEQ,  0, 1, 4'b0000, 0, F,     0, 1, 4'b0000);
    step("beq_exec",    1, I_BEQ,  0, 1, 4'b0000, 0, P,     0, 1, 4'b0000);
    // irq[2] and irq[1] rise together; lowest index served first.
    step("irq_fetch",   1, I_ADD,  0, 1, 4'b0110, 1, F,     0, 1, 4'b0000);
    step("irq_exec",    1, I_ADD,  0, 1, 4'b0110, 1, P|R,   0, 1, 4'b0110);
    step("irq_take1",   1, I_ADDI, 0, 1, 4'b0110, 1, P|I,   1, 1, 4'b0110);
    step("irq_fetch2",  1, I_ADDI, 0, 1, 4'b0110, 1, F,     1, 1, 4'b0100);
    step("irq_exec2",   1, I_ADDI, 0, 1, 4'b0110, 1, P|R,   1, 1, 4'b0100);
    step("irq_take2",   1, I_ADDI, 0, 1, 4'b0110, 1, P|I,   2, 1, 4'b0100);
    step("irq_clear",   1, I_ADDI, 0, 1, 4'b0000, 1, F,     2, 1, 4'b0000);
    step("irq_after",   1, I_ADDI, 0, 1, 4'b0000, 1, P|R,   2, 1, 4'b0000);
    // Level-mode line 3 mirrors irq; irq_en low so nothing is taken.
    step("lvl_fetch",   1, I_ADDI, 0, 1, 4'b1000, 0, F,     2, 1, 4'b0000);
    step("lvl_exec",    1, I_ADDI, 0, 1, 4'b1000, 0, P|R,   2, 1, 4'b1000);
    step("lvl_drop",    1, I_ADDI, 0, 1, 4'b0000, 0, F,     2, 1, 4'b1000);
    step("lvl_gone",    1, I_ADDI, 0, 1, 4'b0000, 0, P|R,   2, 1, 4'b0000);
    // irq[0] during LW wait: deferred until WR_BK completes.
    step("dfr_fetch",   1, I_LW,   0, 1, 4'b0000, 1, F,     2, 1, 4'b0000);
    step("dfr_exec",    1, I_LW,   0, 0, 4'b0000, 1, L,     2, 1, 4'b0000);
    step("dfr_wait0",   1, I_LW,   0, 0, 4'b0001, 1, L,     2, 1, 4'b0000);
    step("dfr_wait1",   1, I_LW,   0, 1, 4'b0001, 1, L,     2, 1, 4'b0001);
    step("dfr_wrbk",    1, I_LW,   0, 1, 4'b0001, 1, P|R,   2, 1, 4'b0001);
    step("dfr_take",    1, I_ADDI, 0, 1, 4'b0001, 1, P|I,   0, 1, 4'b0001);
    step("dfr_fetch2",  1, I_ADDI, 0, 1, 4'b0000, 1, F,     0, 1, 4'b0000);
    step("dfr_exec2",   1, I_ADDI, 0, 1, 4'b0000, 0, P|R,   0, 1, 4'b0000);
    // Async reset in the middle of MEM_WAIT with a pending line.
    step("rst_fetch",   1, I_LW,   0, 1, 4'b0010, 0, F,     0, 1, 4'b0000);
    step("rst_exec",    1, I_LW,   0, 0, 4'b0010, 0, L,     0, 1, 4'b0010);
    step("rst_wait0",   1, I_LW,   0, 0, 4'b0010, 0, L,     0, 1, 4'b0010);
    step("rst_assert",  0, I_LW,   0, 0, 4'b0010, 0, C,     0, 0, 4'b0000);
    step("rst_hold",    0, I_ADDI, 0, 1, 4'b0000, 0, C,     0, 0, 4'b0000);
    step("rst_init",    1, I_ADDI, 0, 1, 4'b0000, 0, C,     0, 0, 4'b0000);
    step("rst_fetch2",  1, I_ADDI, 0, 1, 4'b0000, 0, F,     0, 0, 4'b0000);
    step("rst_exec2",   1, I_ADDI, 0, 1, 4'b0000, 0, P|R,   0, 0, 4'b0000);
    stim_done = 1'b1;
  end

endmodule
